// File: rtl/bsg_dmc_clk_div_rst_seq_if.sv
// Config channel bundle for bsg_dmc_clk_div_rst_seq.
//   v       config valid
//   ready_c config ready (combinational from the slave)
//   chan    target divider channel
//   div     new divide value D (output period = 2*(D+1) clock cycles)
//   en      channel enable
interface bsg_dmc_clk_div_rst_seq_if #(
  parameter int unsigned num_clk_p   = 2,
  parameter int unsigned div_width_p = 4
);
  localparam int unsigned chan_width_lp = (num_clk_p > 1) ? $clog2(num_clk_p) : 1;

  logic                     v;
  logic                     ready_c;
  logic [chan_width_lp-1:0] chan;
  logic [div_width_p-1:0]   div;
  logic                     en;

  modport master (output v, chan, div, en, input ready_c);
  modport slave  (input v, chan, div, en, output ready_c);
endinterface

// File: rtl/bsg_dmc_clk_div_rst_seq.sv
// Multi-channel programmable clock divider plus ordered reset-release sequencer.
// Ports:
//   clk_i            2x DFI clock
//   async_reset_n_i  asynchronous active-low reset
//   cfg              config handshake (slave side): valid/ready, chan, div, en
//   clk_o            divided clocks, one per channel, registered
//   rst_start_i      pulse that starts the reset-release sequence
//   rst_dly_i        cycles between release steps (0 treated as 1), sampled at start
//   reset_o          active-high sequenced resets, released in index order
//   rst_busy_o       sequence in progress
//   rst_done_o       all resets released
module bsg_dmc_clk_div_rst_seq #(
  parameter int unsigned num_clk_p       = 2,
  parameter int unsigned div_width_p     = 4,
  parameter int unsigned num_rst_p       = 3,
  parameter int unsigned rst_dly_width_p = 8
) (
  input  logic                       clk_i,
  input  logic                       async_reset_n_i,
  bsg_dmc_clk_div_rst_seq_if.slave   cfg,
  output logic [num_clk_p-1:0]       clk_o,
  input  logic                       rst_start_i,
  input  logic [rst_dly_width_p-1:0] rst_dly_i,
  output logic [num_rst_p-1:0]       reset_o,
  output logic                       rst_busy_o,
  output logic                       rst_done_o
);

  localparam int unsigned chan_width_lp = (num_clk_p > 1) ? $clog2(num_clk_p) : 1;
  localparam int unsigned chan_pad_lp   = 1 << chan_width_lp;
  localparam int unsigned idx_width_lp  = (num_rst_p > 1) ? $clog2(num_rst_p) : 1;

  // ---------------------------------------------------------------------------
  // Config handshake: channels past num_clk_p read as never pending, so those
  // transfers are accepted and dropped.
  logic [num_clk_p-1:0]   pending;
  logic [chan_pad_lp-1:0] pending_pad;

  assign pending_pad = chan_pad_lp'(pending);
  assign cfg.ready_c = ~pending_pad[cfg.chan];

  // ---------------------------------------------------------------------------
  // Divider channels
  for (genvar c = 0; c < num_clk_p; c++) begin : g_chan
    logic                   fire;
    logic                   at_end;
    logic                   clk_q;
    logic                   en_q;
    logic                   pending_q;
    logic                   sh_en_q;
    logic [div_width_p-1:0] cnt_q;
    logic [div_width_p-1:0] div_q;
    logic [div_width_p-1:0] sh_div_q;

    assign fire   = cfg.v & cfg.ready_c & (cfg.chan == chan_width_lp'(c));
    assign at_end = (cnt_q == div_q);

    // A disabled channel applies its shadow at once; an enabled one waits for
    // the end of its high phase so the switch lands on a falling edge.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
      if (!async_reset_n_i) begin
        clk_q     <= 1'b0;
        en_q      <= 1'b0;
        pending_q <= 1'b0;
        sh_en_q   <= 1'b0;
        cnt_q     <= '0;
        div_q     <= '0;
        sh_div_q  <= '0;
      end else begin
        if (fire) begin
          sh_div_q  <= cfg.div;
          sh_en_q   <= cfg.en;
          pending_q <= 1'b1;
        end
        if (!en_q) begin
          cnt_q <= '0;
          clk_q <= 1'b0;
          if (pending_q) begin
            div_q     <= sh_div_q;
            en_q      <= sh_en_q;
            pending_q <= 1'b0;
          end
        end else if (at_end) begin
          cnt_q <= '0;
          clk_q <= ~clk_q;
          if (pending_q && clk_q) begin
            div_q     <= sh_div_q;
            en_q      <= sh_en_q;
            pending_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + div_width_p'(1);
        end
      end
    end

    assign pending[c] = pending_q;
    assign clk_o[c]   = clk_q;
  end

  // ---------------------------------------------------------------------------
  // Reset-release sequencer
  typedef enum logic [1:0] {
    st_idle,
    st_hold,
    st_rel,
    st_done
  } seq_state_e;

  seq_state_e                 state_r,  state_next;
  logic [rst_dly_width_p-1:0] dly_r,    dly_next;
  logic [rst_dly_width_p-1:0] step_r,   step_next;
  logic [idx_width_lp-1:0]    idx_r,    idx_next;
  logic [num_rst_p-1:0]       reset_r,  reset_next;
  logic                       busy_r,   busy_next;
  logic                       done_r,   done_next;
  logic                       step_last;
  logic                       idx_last;

  // State register
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_r <= st_idle;
      dly_r   <= '0;
      step_r  <= '0;
      idx_r   <= '0;
      reset_r <= '1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      dly_r   <= dly_next;
      step_r  <= step_next;
      idx_r   <= idx_next;
      reset_r <= reset_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
    end
  end

  assign step_last = (step_r == (dly_r - rst_dly_width_p'(1)));
  assign idx_last  = (idx_r == idx_width_lp'(num_rst_p - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_next = state_r;
    dly_next   = dly_r;
    step_next  = step_r;
    idx_next   = idx_r;
    reset_next = reset_r;
    busy_next  = busy_r;
    done_next  = done_r;

    case (state_r)
      st_idle, st_done: begin
        if (rst_start_i) begin
          state_next = st_hold;
          dly_next   = (rst_dly_i == '0) ? rst_dly_width_p'(1) : rst_dly_i;
          step_next  = '0;
          idx_next   = '0;
          reset_next = '1;
          busy_next  = 1'b1;
          done_next  = 1'b0;
        end
      end
      st_hold: begin
        if (step_last) begin
          state_next = st_rel;
          step_next  = '0;
          idx_next   = '0;
        end else begin
          step_next = step_r + rst_dly_width_p'(1);
        end
      end
      st_rel: begin
        if (step_last) begin
          step_next         = '0;
          reset_next[idx_r] = 1'b0;
          if (idx_last) begin
            state_next = st_done;
            reset_next = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_r + idx_width_lp'(1);
          end
        end else begin
          step_next = step_r + rst_dly_width_p'(1);
        end
      end
      default: state_next = st_idle;
    endcase
  end

  assign reset_o    = reset_r;
  assign rst_busy_o = busy_r;
  assign rst_done_o = done_r;

endmodule
